// File: rtl/booth_r4_datapath_if.sv
// Operand/result bundle for booth_r4_datapath.
// master: operand source and sequencer (drives sel/o_en/a/b).
// slave : the datapath (drives product/valid/busy/seq_err).
interface booth_r4_datapath_if #(
    parameter int WIDTH = 8
) ();
    logic                 sel;
    logic                 o_en;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   product;
    logic                 valid;
    logic                 busy;
    logic                 seq_err;

    modport master (
        output sel, o_en, a, b,
        input  product, valid, busy, seq_err
    );

    modport slave (
        input  sel, o_en, a, b,
        output product, valid, busy, seq_err
    );
endinterface

// File: rtl/booth_r4_datapath.sv
// Sequential radix-4 Booth multiplier datapath.
// sel=0 loads operands, sel=1 retires one Booth digit per clock,
// o_en captures the finished signed product. seq_err is a sticky flag
// for a capture requested before all WIDTH/2 digits were retired.
// WIDTH must be even and >= 4.
// Optional macro BOOTH_DP_OUTREG_EN: extra output register stage on
// product/valid (one more clock of latency; seq_err unaffected).
module booth_r4_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    booth_r4_datapath_if.slave    bus
);

    localparam int NSTEP = WIDTH / 2;
    localparam int AW    = WIDTH + 2;
    localparam int SW    = $clog2(NSTEP + 1);

    typedef enum logic [1:0] {
        S_IDLE,   // nothing loaded since reset
        S_RUN,    // digits remaining
        S_DONE    // all digits retired, result in {acc, q}
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       m_q, m_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [AW-1:0]          acc_q, acc_d;
    logic                   qm1_q, qm1_d;
    logic [SW-1:0]          step_q, step_d;
    logic                   seq_err_q, seq_err_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic                   valid_q, valid_d;

    logic [AW-1:0]          m_ext;
    logic [AW-1:0]          m_x2;
    logic [AW-1:0]          addend;
    logic [AW-1:0]          sum;

    // Booth digit recoding and partial-sum adder
    always_comb begin
        m_ext = {{2{m_q[WIDTH-1]}}, m_q};
        m_x2  = m_ext << 1;
        addend = '0;
        unique case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_x2;
            3'b100:         addend = -m_x2;
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        sum = acc_q + addend;
    end

    // Next-state: capture is judged on pre-load state, then load/step
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        qm1_d     = qm1_q;
        step_d    = step_q;
        seq_err_d = seq_err_q;
        prod_d    = prod_q;
        valid_d   = 1'b0;

        if (bus.o_en) begin
            if (state_q == S_DONE) begin
                prod_d  = {acc_q[WIDTH-1:0], q_q};
                valid_d = 1'b1;
            end else begin
                seq_err_d = 1'b1;
            end
        end

        if (!bus.sel) begin
            // Load overrides any error raised by a same-cycle capture
            m_d       = bus.a;
            q_d       = bus.b;
            acc_d     = '0;
            qm1_d     = 1'b0;
            step_d    = '0;
            seq_err_d = 1'b0;
            state_d   = S_RUN;
        end else if (state_q == S_RUN) begin
            // Arithmetic shift right by 2 of {sum, q, qm1}
            acc_d  = {{2{sum[AW-1]}}, sum[AW-1:2]};
            q_d    = {sum[1:0], q_q[WIDTH-1:2]};
            qm1_d  = q_q[1];
            step_d = step_q + SW'(1);
            if (step_q == SW'(NSTEP - 1)) begin
                state_d = S_DONE;
            end
        end
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            qm1_q     <= 1'b0;
            step_q    <= '0;
            seq_err_q <= 1'b0;
            prod_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            qm1_q     <= qm1_d;
            step_q    <= step_d;
            seq_err_q <= seq_err_d;
            prod_q    <= prod_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.busy    = (state_q == S_RUN);
    assign bus.seq_err = seq_err_q;

`ifdef BOOTH_DP_OUTREG_EN
    logic [2*WIDTH-1:0]     prod_out_q, prod_out_d;
    logic                   valid_out_q, valid_out_d;

    // Output stage feeds straight from the capture register
    always_comb begin
        prod_out_d  = prod_q;
        valid_out_d = valid_q;
    end

    // Extra output pipeline register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prod_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            prod_out_q  <= prod_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.product = prod_out_q;
    assign bus.valid   = valid_out_q;
`else
    assign bus.product = prod_q;
    assign bus.valid   = valid_q;
`endif

endmodule
